// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter for the shared FIFO write port, plus the
// occupancy counter that drives full/empty and gates new grants.
module fifo_wr_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  localparam int IDW   = $clog2(NREQ),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 fifo_wr_en,
  output logic [IDW+DW-1:0]    fifo_wr_data,
  input  logic                 fifo_rd_en,
  output logic [CW-1:0]        fifo_count,
  output logic                 full,
  output logic                 empty,
  output logic [IDW-1:0]       grant_id,
  output logic                 err_underflow
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;
  logic           found;
  logic           space;
  logic           rd_dec;
  logic [DW-1:0]  sel_data;
  int unsigned    idx;

  assign full   = (fifo_count == CW'(DEPTH));
  assign empty  = (fifo_count == '0);
  assign rd_dec = fifo_rd_en & ~empty;

  // The pending write strobe already owns a slot, so it counts against space;
  // a same-cycle read only frees a slot once it has reached the counter.
  assign space = (({1'b0, fifo_count} + {{CW{1'b0}}, fifo_wr_en}) < (CW + 1)'(DEPTH));

  always_comb begin
    req_ready = '0;
    sel       = '0;
    cand      = '0;
    found     = 1'b0;
    idx       = 0;
    if (rst_n && !flush && space) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx  = (32'(rr_ptr) + k) % NREQ;
        cand = IDW'(idx);
        if (!found && req_valid[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
      if (found) req_ready[sel] = 1'b1;
    end
  end

  assign sel_data = req_data[32'(sel)*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= '0;
      fifo_count    <= '0;
      grant_id      <= '0;
      err_underflow <= 1'b0;
    end else if (flush) begin
      // An in-flight strobe is still presented this cycle but never counted.
      rr_ptr        <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_count    <= '0;
      err_underflow <= 1'b0;
    end else begin
      fifo_wr_en <= found;
      if (found) begin
        fifo_wr_data <= {sel, sel_data};
        grant_id     <= sel;
        rr_ptr       <= (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
      end
      fifo_count <= fifo_count + CW'(fifo_wr_en) - CW'(rd_dec);
      if (fifo_rd_en && empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a cycle model feeds a scoreboard of
// expected FIFO words, and each scenario task adds its own targeted checks.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int IDW   = $clog2(NREQ);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_wr_en;
  logic [IDW+DW-1:0]    fifo_wr_data;
  logic                 fifo_rd_en = 1'b0;
  logic [CW-1:0]        fifo_count;
  logic                 full;
  logic                 empty;
  logic [IDW-1:0]       grant_id;
  logic                 err_underflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  int  m_ptr = 0;
  int  m_cnt = 0;
  bit  m_wr  = 1'b0;
  bit  m_err = 1'b0;
  int  m_gid = 0;
  logic [IDW+DW-1:0] sb_q[$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .fifo_count(fifo_count),
    .full(full), .empty(empty), .grant_id(grant_id),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic int grant_of(logic [NREQ-1:0] v, int ptr, int cnt, bit wr,
                                  logic fl, logic rn);
    int g = -1;
    if (rn && !fl && (cnt + int'(wr)) < DEPTH)
      for (int k = NREQ - 1; k >= 0; k--)
        if (v[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
    return g;
  endfunction

  // model advances on each rising edge from the same stable inputs the DUT sees
  initial begin
    forever begin
      int g;
      @(posedge clk);
      g = grant_of(req_valid, m_ptr, m_cnt, m_wr, flush, rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_wr = 0; m_err = 0; m_ptr = 0; m_gid = 0;
        sb_q.delete();
      end else if (flush) begin
        m_cnt = 0; m_wr = 0; m_err = 0; m_ptr = 0;
      end else begin
        if (fifo_rd_en && m_cnt == 0) m_err = 1;
        m_cnt = m_cnt + int'(m_wr) - ((fifo_rd_en && m_cnt != 0) ? 1 : 0);
        if (g >= 0) begin
          sb_q.push_back({IDW'(g), req_data[g*DW +: DW]});
          m_ptr = (g + 1) % NREQ;
          m_gid = g;
        end
        m_wr = (g >= 0);
      end
    end
  end

  // scoreboard and per-cycle state comparison, away from the active edge
  initial begin
    forever begin
      int g;
      logic [NREQ-1:0] exp_r;
      logic [IDW+DW-1:0] exp_w;
      @(negedge clk);
      g = grant_of(req_valid, m_ptr, m_cnt, m_wr, flush, rst_n);
      exp_r = (g >= 0) ? (NREQ'(1) << g) : '0;
      checks++;
      if (req_ready !== exp_r) begin
        errors++;
        $display("FAIL sb_ready @%0t: got %b expected %b", $time, req_ready, exp_r);
      end
      checks++;
      if (fifo_count !== CW'(m_cnt) || full !== (m_cnt == DEPTH) || empty !== (m_cnt == 0)) begin
        errors++;
        $display("FAIL sb_count @%0t: got count=%0d full=%b empty=%b expected count=%0d",
                 $time, fifo_count, full, empty, m_cnt);
      end
      checks++;
      if (err_underflow !== m_err || fifo_wr_en !== m_wr || grant_id !== IDW'(m_gid)) begin
        errors++;
        $display("FAIL sb_flags @%0t: got err=%b wr_en=%b gid=%0d expected err=%b wr_en=%b gid=%0d",
                 $time, err_underflow, fifo_wr_en, grant_id, m_err, m_wr, m_gid);
      end
      if (m_wr) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_data @%0t: got %h expected no pending entry", $time, fifo_wr_data);
        end else begin
          exp_w = sb_q.pop_front();
          if (fifo_wr_data !== exp_w) begin
            errors++;
            $display("FAIL sb_data @%0t: got %h expected %h", $time, fifo_wr_data, exp_w);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_data = NREQ*DW'($urandom);
    repeat (3) begin
      next_cycle();
      checks++;
      if (req_ready !== '0 || empty !== 1'b1 || fifo_count !== '0) begin
        errors++;
        $display("FAIL reset_hold: got ready=%b empty=%b count=%0d expected 0000/1/0",
                 req_ready, empty, fifo_count);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
    end
    checks++;
    if (fifo_wr_data !== '0 || grant_id !== '0 || fifo_wr_en !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got data=%h gid=%0d wr_en=%b full=%b expected 0/0/0/0",
               fifo_wr_data, grant_id, fifo_wr_en, full);
    end
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_round_robin();
    int nwr = 0;
    int idx;
    for (int c = 0; c < 30; c++) begin
      req_valid = '1;
      req_data  = NREQ*DW'($urandom);
      #1;
      if (req_ready !== '0) begin
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        checks++;
        if (idx != nwr % NREQ || !$onehot(req_ready)) begin
          errors++;
          $display("FAIL rr_order: got ready=%b expected requester %0d", req_ready, nwr % NREQ);
        end
        nwr++;
      end
      next_cycle();
    end
    #1;
    checks++;
    if (nwr != DEPTH) begin
      errors++;
      $display("FAIL rr_write_total: got %0d expected %0d", nwr, DEPTH);
    end
    checks++;
    if (full !== 1'b1 || req_ready !== '0 || fifo_count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL rr_full: got full=%b ready=%b count=%0d expected 1/0000/%0d",
               full, req_ready, fifo_count, DEPTH);
    end
  endtask

  task automatic test_full_boundary();
    req_valid = '1; fifo_rd_en = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL full_read_no_grant: got %b expected 0000", req_ready);
    end
    next_cycle();
    fifo_rd_en = 1'b0;
    #1;
    checks++;
    if (fifo_count !== CW'(DEPTH - 1) || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL full_one_grant: got count=%0d ready=%b expected %0d/0001",
               fifo_count, req_ready, DEPTH - 1);
    end
    next_cycle();
    checks++;
    if (req_ready !== '0 || fifo_wr_en !== 1'b1 || fifo_count !== CW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_pending_block: got ready=%b wr_en=%b count=%0d expected 0000/1/%0d",
               req_ready, fifo_wr_en, fifo_count, DEPTH - 1);
    end
    next_cycle();
    checks++;
    if (fifo_count !== CW'(DEPTH) || full !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL full_again: got count=%0d full=%b ready=%b expected %0d/1/0000",
               fifo_count, full, req_ready, DEPTH);
    end
    req_valid = '0; fifo_rd_en = 1'b1;
    repeat (DEPTH - 5) next_cycle();
    fifo_rd_en = 1'b0;
  endtask

  task automatic test_simul_rw();
    req_valid = 4'b0010;
    #1;
    checks++;
    if (fifo_count !== CW'(5) || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL simul_setup: got count=%0d ready=%b expected 5/0010", fifo_count, req_ready);
    end
    next_cycle();
    req_valid = '0; fifo_rd_en = 1'b1;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_count !== CW'(5)) begin
      errors++;
      $display("FAIL simul_pending: got wr_en=%b count=%0d expected 1/5", fifo_wr_en, fifo_count);
    end
    next_cycle();
    fifo_rd_en = 1'b0;
    checks++;
    if (fifo_count !== CW'(5) || full !== 1'b0 || empty !== 1'b0 || grant_id !== IDW'(1)) begin
      errors++;
      $display("FAIL simul_result: got count=%0d full=%b empty=%b gid=%0d expected 5/0/0/1",
               fifo_count, full, empty, grant_id);
    end
  endtask

  task automatic test_underflow();
    fifo_rd_en = 1'b1;
    repeat (5) next_cycle();
    checks++;
    if (fifo_count !== '0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_drained: got count=%0d err=%b expected 0/0", fifo_count, err_underflow);
    end
    next_cycle();
    fifo_rd_en = 1'b0;
    checks++;
    if (fifo_count !== '0 || err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_set: got count=%0d err=%b expected 0/1", fifo_count, err_underflow);
    end
    req_valid = 4'b1000;
    repeat (3) next_cycle();
    req_valid = '0;
    repeat (2) next_cycle();
    checks++;
    if (fifo_count !== CW'(3) || err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky: got count=%0d err=%b expected 3/1", fifo_count, err_underflow);
    end
  endtask

  task automatic test_flush();
    req_valid = '1;
    repeat (7) next_cycle();
    checks++;
    if (fifo_count !== CW'(9) || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: got count=%0d wr_en=%b expected 9/1", fifo_count, fifo_wr_en);
    end
    flush = 1'b1; req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL flush_ready: got %b expected 0000", req_ready);
    end
    next_cycle();
    flush = 1'b0; req_valid = 4'b1101;
    #1;
    checks++;
    if (fifo_count !== '0 || err_underflow !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got count=%0d err=%b wr_en=%b expected 0/0/0",
               fifo_count, err_underflow, fifo_wr_en);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL flush_ptr: got %b expected 0001", req_ready);
    end
    next_cycle();
    req_valid = '0;
    repeat (2) next_cycle();
    checks++;
    if (fifo_count !== CW'(1) || grant_id !== '0) begin
      errors++;
      $display("FAIL flush_resume: got count=%0d gid=%0d expected 1/0", fifo_count, grant_id);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full_boundary();
    test_simul_rw();
    test_underflow();
    test_flush();
    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
